// File: rtl/seven_seg_scan_controller_if.sv
// Signal bundle between a display data source and the seven-segment scan controller.
// The master drives digit data and control; the slave drives the decoder and segment lines.
interface seven_seg_scan_controller_if;
   logic        en;
   logic        load;
   logic [31:0] digit_data;
   logic [7:0]  dp_in;
   logic [7:0]  blank_mask;
   logic        sel_a;
   logic        sel_b;
   logic        sel_c;
   logic        dec_en_n;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic        frame_done;

   modport master (
      output en, load, digit_data, dp_in, blank_mask,
      input  sel_a, sel_b, sel_c, dec_en_n, seg_n, dp_n, frame_done
   );

   modport slave (
      input  en, load, digit_data, dp_in, blank_mask,
      output sel_a, sel_b, sel_c, dec_en_n, seg_n, dp_n, frame_done
   );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed scan controller for an 8-digit common-anode display with blanking gaps
// between digits and frame-synchronous (double-buffered) data updates.
module seven_seg_scan_controller #(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input logic                        clk,
   input logic                        rst,
   seven_seg_scan_controller_if.slave bus
);
   localparam int unsigned    CntW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CntW-1:0] CntLast      = CntW'(PRESCALE - 1);
   localparam logic [CntW-1:0] CntBlankLast = CntW'(BLANK_CYCLES - 1);
   localparam logic [2:0]      IdxLast      = 3'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;

   logic [31:0] stg_data_q, stg_data_d, shd_data_q, shd_data_d;
   logic [7:0]  stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
   logic [7:0]  stg_bm_q, stg_bm_d, shd_bm_q, shd_bm_d;
   logic        pending_q, pending_d;
   logic        at_boundary;

   logic [2:0] sel_q, sel_d;
   logic       dec_en_n_q, dec_en_n_d;
   logic [6:0] seg_n_q, seg_n_d;
   logic       dp_n_q, dp_n_d;
   logic       frame_done_q, frame_done_d;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         StIdle: begin
            if (bus.en) begin
               state_d = StBlank;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         StBlank, StShow: begin
            if (!bus.en) begin
               state_d = StIdle;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == CntLast) begin
               // idx only moves on entry to BLANK, so select never changes while a digit is lit
               state_d = StBlank;
               cnt_d   = '0;
               idx_d   = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntBlankLast) state_d = StShow;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   assign at_boundary = (state_q == StShow) && (idx_q == IdxLast) && (cnt_q == CntLast);

   always_comb begin
      stg_data_d = stg_data_q;
      stg_dp_d   = stg_dp_q;
      stg_bm_d   = stg_bm_q;
      shd_data_d = shd_data_q;
      shd_dp_d   = shd_dp_q;
      shd_bm_d   = shd_bm_q;
      pending_d  = pending_q;
      if (state_q == StIdle) begin
         shd_data_d = stg_data_q;
         shd_dp_d   = stg_dp_q;
         shd_bm_d   = stg_bm_q;
      end else if (at_boundary) begin
         if (bus.load) begin
            shd_data_d = bus.digit_data;
            shd_dp_d   = bus.dp_in;
            shd_bm_d   = bus.blank_mask;
         end else if (pending_q) begin
            shd_data_d = stg_data_q;
            shd_dp_d   = stg_dp_q;
            shd_bm_d   = stg_bm_q;
         end
         pending_d = 1'b0;
      end
      if (bus.load) begin
         stg_data_d = bus.digit_data;
         stg_dp_d   = bus.dp_in;
         stg_bm_d   = bus.blank_mask;
         if (!at_boundary) pending_d = 1'b1;
      end
   end

   // Outputs are decoded from next state so the registered pins line up with the FSM state
   always_comb begin
      sel_d        = idx_d;
      dec_en_n_d   = 1'b1;
      seg_n_d      = 7'h7F;
      dp_n_d       = 1'b1;
      frame_done_d = (state_d == StShow) && (idx_d == IdxLast) && (cnt_d == CntLast);
      if (state_d == StShow) begin
         seg_n_d    = hex7(shd_data_d[{idx_d, 2'b00} +: 4]);
         dp_n_d     = ~shd_dp_d[idx_d];
         dec_en_n_d = shd_bm_d[idx_d];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_data_q   <= '0;
         stg_dp_q     <= '0;
         stg_bm_q     <= '0;
         shd_data_q   <= '0;
         shd_dp_q     <= '0;
         shd_bm_q     <= '0;
         pending_q    <= 1'b0;
         sel_q        <= 3'd0;
         dec_en_n_q   <= 1'b1;
         seg_n_q      <= 7'h7F;
         dp_n_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         stg_data_q   <= stg_data_d;
         stg_dp_q     <= stg_dp_d;
         stg_bm_q     <= stg_bm_d;
         shd_data_q   <= shd_data_d;
         shd_dp_q     <= shd_dp_d;
         shd_bm_q     <= shd_bm_d;
         pending_q    <= pending_d;
         sel_q        <= sel_d;
         dec_en_n_q   <= dec_en_n_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.sel_a      = sel_q[2];
   assign bus.sel_b      = sel_q[1];
   assign bus.sel_c      = sel_q[0];
   assign bus.dec_en_n   = dec_en_n_q;
   assign bus.seg_n      = seg_n_q;
   assign bus.dp_n       = dp_n_q;
   assign bus.frame_done = frame_done_q;
endmodule
